data_memory: RTL and testbench

Parametrised RV32I data memory: byte-addressed, little-endian, single port, with byte/halfword/word loads and stores, load sign/zero extension, registered read data with a VALID strobe, and misaligned-access detection. It sits in the memory stage of the risc32i core and supersedes the fixed 1024×32 word-addressed RAM. The memory accepts one request per cycle with no back-pressure.

---
 rtl/data_memory.sv | 111 +++++++++++
 tb/tb_data_memory.sv | 126 ++++++++++++
 2 files changed

// File: rtl/data_memory.sv
// Byte-addressed little-endian RV32I data memory: byte/half/word loads and stores,
// load sign/zero extension, one-cycle registered response with misalignment error.
module data_memory #(
  parameter int ADDR_WIDTH = 12
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  REQ,
  input  logic                  WRITE_ENABLE,
  input  logic [1:0]            SIZE,
  input  logic                  UNSIGNED,
  input  logic [ADDR_WIDTH-1:0] ADDRESS,
  input  logic [31:0]           DATA_IN,
  output logic [31:0]           DATA_OUT,
  output logic                  VALID,
  output logic                  ERROR
);

  localparam int WORDS = 2 ** (ADDR_WIDTH - 2);

  logic [3:0][7:0] mem [WORDS];

  logic [ADDR_WIDTH-3:0] word_idx_p0;
  logic [1:0]            lane_p0;
  logic                  legal_p0;
  logic [3:0]            lane_we_p0;
  logic [3:0][7:0]       wdata_p0;
  logic [31:0]           rword_p0;
  logic [31:0]           rdata_p0;
  logic                  store_p0;

  function automatic logic is_legal(input logic [1:0] size, input logic [1:0] lane);
    case (size)
      2'b00:   is_legal = 1'b1;
      2'b01:   is_legal = ~lane[0];
      2'b10:   is_legal = (lane == 2'b00);
      default: is_legal = 1'b0;
    endcase
  endfunction

  // Selected field is shifted to bit 0, then widened through a signed variable
  // so sign extension comes from the assignment itself.
  function automatic logic [31:0] load_extend(input logic [31:0] word, input logic [1:0] lane,
                                              input logic [1:0] size, input logic zext);
    logic [31:0]        shifted;
    logic signed [7:0]  b_s;
    logic signed [15:0] h_s;
    logic signed [31:0] w_s;
    shifted = word >> {lane, 3'b000};
    b_s     = shifted[7:0];
    h_s     = shifted[15:0];
    w_s     = '0;
    case (size)
      2'b00:   if (zext) load_extend = {24'b0, shifted[7:0]};
               else begin w_s = b_s; load_extend = w_s; end
      2'b01:   if (zext) load_extend = {16'b0, shifted[15:0]};
               else begin w_s = h_s; load_extend = w_s; end
      default: load_extend = word;
    endcase
  endfunction

  // Request decode (p0): address split, legality, lane enables and replicated store data
  always_comb begin
    word_idx_p0 = ADDRESS[ADDR_WIDTH-1:2];
    lane_p0     = ADDRESS[1:0];
    legal_p0    = is_legal(SIZE, lane_p0);
    lane_we_p0  = 4'b0000;
    wdata_p0    = DATA_IN;
    case (SIZE)
      2'b00: begin
        lane_we_p0 = 4'b0001 << lane_p0;
        wdata_p0   = {4{DATA_IN[7:0]}};
      end
      2'b01: begin
        lane_we_p0 = lane_p0[1] ? 4'b1100 : 4'b0011;
        wdata_p0   = {2{DATA_IN[15:0]}};
      end
      2'b10:   lane_we_p0 = 4'b1111;
      default: lane_we_p0 = 4'b0000;
    endcase
    store_p0 = RST_N & REQ & WRITE_ENABLE & legal_p0;
    rword_p0 = mem[word_idx_p0];
    rdata_p0 = load_extend(rword_p0, lane_p0, SIZE, UNSIGNED);
  end

  // Array write at the request edge; contents deliberately survive reset
  always_ff @(posedge CLK) begin
    if (store_p0) begin
      for (int i = 0; i < 4; i++) begin
        if (lane_we_p0[i]) mem[word_idx_p0][i] <= wdata_p0[i];
      end
    end
  end

  // Response register (p1): stores and idle cycles leave DATA_OUT untouched
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      DATA_OUT <= '0;
      VALID    <= 1'b0;
      ERROR    <= 1'b0;
    end else begin
      VALID <= REQ;
      ERROR <= REQ & ~legal_p0;
      if (REQ) begin
        if (!legal_p0)         DATA_OUT <= '0;
        else if (!WRITE_ENABLE) DATA_OUT <= rdata_p0;
      end
    end
  end

endmodule

// File: tb/tb_data_memory.sv
// Directed bench for data_memory: a 12-bit-address instance for the main sequence
// and an 8-bit-address instance for the top/bottom word aliasing check.
module tb_data_memory;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        a_rst_n, a_req, a_we, a_uns;
  logic [1:0]  a_size;
  logic [11:0] a_addr;
  logic [31:0] a_din, a_dout;
  logic        a_valid, a_error;

  logic        b_rst_n, b_req, b_we, b_uns;
  logic [1:0]  b_size;
  logic [7:0]  b_addr;
  logic [31:0] b_din, b_dout;
  logic        b_valid, b_error;

  int n_checks = 0;
  int n_fails  = 0;

  data_memory #(.ADDR_WIDTH(12)) dut_a (
    .CLK(clk), .RST_N(a_rst_n), .REQ(a_req), .WRITE_ENABLE(a_we), .SIZE(a_size),
    .UNSIGNED(a_uns), .ADDRESS(a_addr), .DATA_IN(a_din), .DATA_OUT(a_dout),
    .VALID(a_valid), .ERROR(a_error)
  );

  data_memory #(.ADDR_WIDTH(8)) dut_b (
    .CLK(clk), .RST_N(b_rst_n), .REQ(b_req), .WRITE_ENABLE(b_we), .SIZE(b_size),
    .UNSIGNED(b_uns), .ADDRESS(b_addr), .DATA_IN(b_din), .DATA_OUT(b_dout),
    .VALID(b_valid), .ERROR(b_error)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic check_a(input string tag, input logic v, input logic e, input logic [31:0] d);
    check({tag, ".valid"}, {31'b0, a_valid}, {31'b0, v});
    check({tag, ".error"}, {31'b0, a_error}, {31'b0, e});
    check({tag, ".data"},  a_dout, d);
  endtask

  task automatic acc_a(input logic rq, input logic we, input logic [1:0] sz, input logic un,
                       input logic [11:0] ad, input logic [31:0] dt);
    @(negedge clk);
    a_req = rq; a_we = we; a_size = sz; a_uns = un; a_addr = ad; a_din = dt;
    @(posedge clk);
    #1;
  endtask

  task automatic acc_b(input logic we, input logic [7:0] ad, input logic [31:0] dt);
    @(negedge clk);
    b_req = 1'b1; b_we = we; b_size = 2'b10; b_uns = 1'b0; b_addr = ad; b_din = dt;
    @(posedge clk);
    #1;
    b_req = 1'b0;
  endtask

  initial begin
    a_rst_n = 1'b0; a_req = 1'b0; a_we = 1'b0; a_size = 2'b00; a_uns = 1'b0; a_addr = '0; a_din = '0;
    b_rst_n = 1'b0; b_req = 1'b0; b_we = 1'b0; b_size = 2'b00; b_uns = 1'b0; b_addr = '0; b_din = '0;
    repeat (2) @(posedge clk);
    #1;
    check_a("reset", 1'b0, 1'b0, 32'h0);
    a_rst_n = 1'b1;
    b_rst_n = 1'b1;

    // Word store then load, then sub-word loads of the same word
    acc_a(1, 1, 2'b10, 0, 12'h004, 32'h80818283); check_a("sw4",    1, 0, 32'h00000000);
    acc_a(1, 0, 2'b10, 0, 12'h004, 32'h0);        check_a("lw4",    1, 0, 32'h80818283);
    acc_a(1, 0, 2'b00, 0, 12'h004, 32'h0);        check_a("lb4",    1, 0, 32'hFFFFFF83);
    acc_a(1, 0, 2'b00, 1, 12'h007, 32'h0);        check_a("lbu7",   1, 0, 32'h00000080);
    acc_a(1, 0, 2'b01, 0, 12'h006, 32'h0);        check_a("lh6",    1, 0, 32'hFFFF8081);
    acc_a(1, 0, 2'b01, 1, 12'h004, 32'h0);        check_a("lhu4",   1, 0, 32'h00008283);

    // Byte store merged into lane 1, read back on the very next cycle
    acc_a(1, 1, 2'b00, 0, 12'h005, 32'h1234565A); check_a("sb5",    1, 0, 32'h00008283);
    acc_a(1, 0, 2'b10, 0, 12'h004, 32'h0);        check_a("lw4m",   1, 0, 32'h80815A83);

    // Misaligned and illegal accesses
    acc_a(1, 1, 2'b10, 0, 12'h000, 32'h01020304); check_a("sw0",    1, 0, 32'h80815A83);
    acc_a(1, 1, 2'b10, 0, 12'h002, 32'hDEADBEEF); check_a("sw2bad", 1, 1, 32'h00000000);
    acc_a(1, 0, 2'b10, 0, 12'h000, 32'h0);        check_a("lw0",    1, 0, 32'h01020304);
    acc_a(1, 0, 2'b10, 0, 12'h004, 32'h0);        check_a("lw4b",   1, 0, 32'h80815A83);
    acc_a(1, 0, 2'b01, 0, 12'h003, 32'h0);        check_a("lh3bad", 1, 1, 32'h00000000);
    acc_a(1, 0, 2'b10, 0, 12'h004, 32'h0);        check_a("lw4c",   1, 0, 32'h80815A83);
    acc_a(1, 0, 2'b11, 0, 12'h000, 32'h0);        check_a("sz3bad", 1, 1, 32'h00000000);

    // Idle cycles hold the last load value
    acc_a(1, 0, 2'b00, 1, 12'h006, 32'h0);        check_a("lbu6",   1, 0, 32'h00000081);
    acc_a(0, 0, 2'b10, 0, 12'h000, 32'h0);        check_a("idle1",  0, 0, 32'h00000081);
    acc_a(0, 1, 2'b10, 0, 12'h004, 32'h0);        check_a("idle2",  0, 0, 32'h00000081);

    // Reset during a store drops it; contents persist
    a_rst_n = 1'b0;
    acc_a(1, 1, 2'b10, 0, 12'h004, 32'h11111111); check_a("rststore", 0, 0, 32'h00000000);
    a_rst_n = 1'b1;
    acc_a(1, 0, 2'b10, 0, 12'h004, 32'h0);        check_a("lw4rst", 1, 0, 32'h80815A83);

    // Halfword store into the upper lanes
    acc_a(1, 1, 2'b01, 0, 12'h006, 32'h9876BEEF); check_a("sh6",    1, 0, 32'h80815A83);
    acc_a(1, 0, 2'b10, 0, 12'h004, 32'h0);        check_a("lw4h",   1, 0, 32'hBEEF5A83);
    acc_a(1, 0, 2'b01, 1, 12'h006, 32'h0);        check_a("lhu6",   1, 0, 32'h0000BEEF);
    acc_a(0, 0, 2'b00, 0, 12'h000, 32'h0);

    // Smaller instance: top and bottom words are independent
    acc_b(1, 8'hFC, 32'hAABBCCDD);
    check("b_swFC.valid", {31'b0, b_valid}, 32'h1);
    acc_b(1, 8'h00, 32'h11223344);
    acc_b(0, 8'hFC, 32'h0);
    check("b_lwFC", b_dout, 32'hAABBCCDD);
    acc_b(0, 8'h00, 32'h0);
    check("b_lw00", b_dout, 32'h11223344);
    check("b_lw00.error", {31'b0, b_error}, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
